// File: rtl/fpu_addsub_param.sv
// rtl/fpu_addsub_param.sv - multi-cycle parametrised FP adder/subtractor; define FPU_RNE_ROUND_EN for round-to-nearest-even (default: truncation)
module fpu_addsub_param #(
    parameter int EXP_W = 11,
    parameter int MAN_W = 20
) (
    input  logic                 clock_100k,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 op_sel,
    input  logic [EXP_W+MAN_W:0] op_a,
    input  logic [EXP_W+MAN_W:0] op_b,
    output logic                 busy,
    output logic                 done,
    output logic [EXP_W+MAN_W:0] data_out,
    output logic [3:0]           status_out
);
    localparam int W  = 1 + EXP_W + MAN_W;
    // extended mantissa: hidden | MAN_W | guard | round | sticky
    localparam int MW = MAN_W + 4;
    // one extra bit for the adder carry-out
    localparam int SW = MW + 1;
    // signed working exponent, wide enough for MAN_W+3 left shifts below 1
    localparam int XW = EXP_W + $clog2(MAN_W + 4) + 2;
    localparam logic [XW-1:0]        DIFF_MAX = XW'(MAN_W + 3);
    localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
    } state_t;

    state_t                 r_state;
    logic [W-1:0]           r_a;
    logic [W-1:0]           r_b;
    logic                   r_sign;
    logic                   r_eff_sub;
    logic                   r_zero;
    logic signed [XW-1:0]   r_exp;
    logic [XW-1:0]          r_diff;
    logic [MW-1:0]          r_ma;
    logic [MW-1:0]          r_mb;
    logic [SW-1:0]          r_sum;
    logic [W-1:0]           r_res;
    logic [3:0]             r_stat;

    logic [EXP_W-1:0]       w_ea;
    logic [EXP_W-1:0]       w_eb;
    logic [MAN_W-1:0]       w_fa;
    logic [MAN_W-1:0]       w_fb;
    logic                   w_swap;
    logic [EXP_W-1:0]       w_big_e;
    logic [EXP_W-1:0]       w_small_e;
    logic [MW-1:0]          w_big_m;
    logic [MW-1:0]          w_small_m;
    logic                   w_sign;
    logic [XW-1:0]          w_diff;

    logic                   w_up;
    logic                   w_inexact;
    logic [MAN_W+1:0]       w_rm;
    logic                   w_rcarry;
    logic signed [XW-1:0]   w_rexp;
    logic [MAN_W-1:0]       w_rman;
    logic [W-1:0]           w_res;
    logic [3:0]             w_stat;

    // Unpack latched operands, flush denormals, order by magnitude
    always_comb begin
        w_ea      = r_a[W-2:MAN_W];
        w_eb      = r_b[W-2:MAN_W];
        w_fa      = (|w_ea) ? r_a[MAN_W-1:0] : '0;
        w_fb      = (|w_eb) ? r_b[MAN_W-1:0] : '0;
        w_swap    = {w_eb, w_fb} > {w_ea, w_fa};
        w_big_e   = w_swap ? w_eb : w_ea;
        w_small_e = w_swap ? w_ea : w_eb;
        w_big_m   = w_swap ? {|w_eb, w_fb, 3'b000} : {|w_ea, w_fa, 3'b000};
        w_small_m = w_swap ? {|w_ea, w_fa, 3'b000} : {|w_eb, w_fb, 3'b000};
        w_sign    = w_swap ? r_b[W-1] : r_a[W-1];
        w_diff    = XW'(w_big_e) - XW'(w_small_e);
    end

    // Round the normalised sum and classify the result
    always_comb begin
        w_inexact = |r_sum[2:0];
`ifdef FPU_RNE_ROUND_EN
        w_up      = r_sum[2] & (r_sum[1] | r_sum[0] | r_sum[3]);
`else
        w_up      = 1'b0;
`endif
        w_rm      = {1'b0, r_sum[MW-1:3]} + {{(MAN_W+1){1'b0}}, w_up};
        w_rcarry  = w_rm[MAN_W+1];
        w_rexp    = r_exp + {{(XW-1){1'b0}}, w_rcarry};
        w_rman    = w_rcarry ? w_rm[MAN_W:1] : w_rm[MAN_W-1:0];
        w_res     = '0;
        w_stat    = 4'b0001;
        if (r_zero) begin
            w_res  = '0;
            w_stat = 4'b0001;
        end else if (w_rexp >= EXP_MAX) begin
            w_res  = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_stat = 4'b0010;
        end else if (w_rexp <= 0) begin
            w_res  = {r_sign, {(W-1){1'b0}}};
            w_stat = 4'b0100;
        end else begin
            w_res  = {r_sign, w_rexp[EXP_W-1:0], w_rman};
            w_stat = w_inexact ? 4'b1000 : 4'b0001;
        end
    end

    // Sequencer: one state per pipeline step, shifts are one bit per cycle
    always_ff @(posedge clock_100k or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_sign     <= 1'b0;
            r_eff_sub  <= 1'b0;
            r_zero     <= 1'b0;
            r_exp      <= '0;
            r_diff     <= '0;
            r_ma       <= '0;
            r_mb       <= '0;
            r_sum      <= '0;
            r_res      <= '0;
            r_stat     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            data_out   <= '0;
            status_out <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= op_a;
                        r_b     <= {op_b[W-1] ^ op_sel, op_b[W-2:0]};
                        r_zero  <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_sign    <= w_sign;
                    r_eff_sub <= r_a[W-1] ^ r_b[W-1];
                    r_exp     <= XW'(w_big_e);
                    r_ma      <= w_big_m;
                    if (w_diff > DIFF_MAX) begin
                        // B lies entirely below the sticky position
                        r_mb   <= {{(MW-1){1'b0}}, |w_small_m};
                        r_diff <= '0;
                    end else begin
                        r_mb   <= w_small_m;
                        r_diff <= w_diff;
                    end
                    r_state <= S_ALIGN;
                end
                S_ALIGN: begin
                    if (r_diff != '0) begin
                        r_mb   <= {1'b0, r_mb[MW-1:2], r_mb[1] | r_mb[0]};
                        r_diff <= r_diff - 1'b1;
                    end
                    if (r_diff <= XW'(1)) begin
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    // swap guarantees |A| >= |B|, so subtraction never goes negative
                    r_sum   <= r_eff_sub ? ({1'b0, r_ma} - {1'b0, r_mb})
                                         : ({1'b0, r_ma} + {1'b0, r_mb});
                    r_state <= S_NORM;
                end
                S_NORM: begin
                    if (r_sum[SW-1]) begin
                        r_sum   <= {1'b0, r_sum[SW-1:2], r_sum[1] | r_sum[0]};
                        r_exp   <= r_exp + 1;
                        r_state <= S_ROUND;
                    end else if (r_sum == '0) begin
                        r_zero  <= 1'b1;
                        r_state <= S_ROUND;
                    end else if (r_sum[MW-1]) begin
                        r_state <= S_ROUND;
                    end else begin
                        r_sum <= r_sum << 1;
                        r_exp <= r_exp - 1;
                        if (r_sum[MW-2]) begin
                            r_state <= S_ROUND;
                        end
                    end
                end
                S_ROUND: begin
                    r_res   <= w_res;
                    r_stat  <= w_stat;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    data_out   <= r_res;
                    status_out <= r_stat;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_addsub_param.sv
// tb/tb_fpu_addsub_param.sv - directed-vector bench for fpu_addsub_param
`timescale 1ns/1ps
module tb_fpu_addsub_param;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op_sel;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] data_out;
    logic [3:0]  status_out;

    int n_checks = 0;
    int n_fail   = 0;

    fpu_addsub_param #(.EXP_W(11), .MAN_W(20)) dut (
        .clock_100k (clk),
        .reset      (rst_n),
        .start      (start),
        .op_sel     (op_sel),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .data_out   (data_out),
        .status_out (status_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one operation and check result, status, latency and busy;
    // poke=1 pulses a conflicting start while the operation is running.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sel, input logic [31:0] exp_res,
                          input logic [3:0] exp_stat, input int exp_lat, input bit poke);
        int cyc;
        bit seen;
        bit busy_ok;
        @(negedge clk);
        op_a   = a;
        op_b   = b;
        op_sel = sel;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc     = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (!seen && cyc < 200) begin
            if (!busy) busy_ok = 1'b0;
            if (poke && cyc == 3) begin
                op_a   = 32'h4008_0000;
                op_b   = 32'h4008_0000;
                op_sel = 1'b1;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check_eq({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        check_eq({tag, "_latency"}, cyc, exp_lat);
        check_eq({tag, "_busy_during"}, {31'd0, busy_ok}, 32'd1);
        check_eq({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_data"}, data_out, exp_res);
        check_eq({tag, "_status"}, {28'd0, status_out}, {28'd0, exp_stat});
    endtask

    initial begin
        int  dones;
        logic [31:0] round_exp;
`ifdef FPU_RNE_ROUND_EN
        round_exp = 32'h3FF0_0001;
`else
        round_exp = 32'h3FF0_0000;
`endif
        rst_n  = 1'b0;
        start  = 1'b0;
        op_sel = 1'b0;
        op_a   = '0;
        op_b   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_data", data_out, 32'd0);
        check_eq("rst_status", {28'd0, status_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("one_plus_one", 32'h3FF0_0000, 32'h3FF0_0000, 1'b0, 32'h4000_0000, 4'b0001, 6, 1'b0);
        run_op("two5_plus_two5", 32'h4004_0000, 32'h4004_0000, 1'b0, 32'h4014_0000, 4'b0001, 6, 1'b0);
        run_op("three_minus_three", 32'h4008_0000, 32'h4008_0000, 1'b1, 32'h0000_0000, 4'b0001, 6, 1'b0);
        run_op("overflow", 32'h7FEF_FFFF, 32'h7FEF_FFFF, 1'b0, 32'h7FF0_0000, 4'b0010, 6, 1'b0);
        run_op("underflow", 32'h0010_0000, 32'h0010_0001, 1'b1, 32'h8000_0000, 4'b0100, 25, 1'b0);
        run_op("rounding", 32'h3FF0_0000, 32'h3EA8_0000, 1'b0, round_exp, 4'b1000, 26, 1'b0);
        run_op("start_while_busy", 32'h3FF0_0000, 32'h3EA8_0000, 1'b0, round_exp, 4'b1000, 26, 1'b1);

        // Abort an operation while it is shifting in ALIGN
        @(negedge clk);
        op_a   = 32'h3FF0_0000;
        op_b   = 32'h3EA8_0000;
        op_sel = 1'b0;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("abort_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_done", {31'd0, done}, 32'd0);
        check_eq("abort_data", data_out, 32'd0);
        check_eq("abort_status", {28'd0, status_out}, 32'd0);
        dones = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check_eq("abort_no_done", dones, 0);
        check_eq("abort_idle_busy", {31'd0, busy}, 32'd0);

        run_op("after_abort", 32'h3FF0_0000, 32'h3FF0_0000, 1'b0, 32'h4000_0000, 4'b0001, 6, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
